// File: rtl/mem_map_spi_fifo_pkg.sv
// Shared definitions for the memory-mapped SPI master: register offsets,
// STATUS/CTRL bit positions and the transfer engine state type.
package mem_map_spi_fifo_pkg;

    localparam logic [7:0] MMSPI_DATA   = 8'h00;
    localparam logic [7:0] MMSPI_STATUS = 8'h04;
    localparam logic [7:0] MMSPI_CTRL   = 8'h08;
    localparam logic [7:0] MMSPI_DIV    = 8'h0C;
    localparam logic [7:0] MMSPI_IE     = 8'h10;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_RX_EMPTY = 3;
    localparam int STAT_BUSY     = 4;
    localparam int STAT_RX_OVF   = 5;
    localparam int STAT_TX_OVF   = 6;

    localparam int CTRL_ENABLE  = 8;
    localparam int CTRL_CLR_OVF = 9;
    localparam int CTRL_FLUSH   = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } mmspi_state_e;

    // A half-period of zero would stall the bit counter, so it is stored as 1.
    function automatic logic [7:0] div_sanitize(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage

// File: rtl/mem_map_spi_fifo_if.sv
// CPU I/O decode port bundle for the SPI master: select, write strobe,
// byte offset, write data and combinational read data.
interface mem_map_spi_fifo_if;
    logic        en;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output en, we, addr, wd, input rd);
    modport slave  (input en, we, addr, wd, output rd);
endinterface

// File: rtl/mem_map_spi_fifo_sync_fifo.sv
// Synchronous FIFO with combinational head; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rp];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop)  rp <= rp + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_map_spi_fifo.sv
// Memory-mapped SPI master (mode 0) with TX/RX FIFOs and programmable SCK.
// Optional feature macro: MEM_MAP_SPI_IRQ_EN (IE register and irq logic).
module mem_map_spi_fifo
    import mem_map_spi_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int NUM_SS         = 1,
    parameter int SCK_WIDTH_CLKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_map_spi_fifo_if.slave     bus,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SS-1:0]     ss,
    output logic                  irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    mmspi_state_e state_q, state_d;

    logic [7:0]        div_reg, div_q, cnt_q;
    logic [2:0]        ss_sel;
    logic              enable, tx_ovf, rx_ovf;
    logic [3:0]        half_q;
    logic [7:0]        tx_sh, rx_sh;
    logic              sck_q, mosi_q;
    logic [NUM_SS-1:0] ss_q, ss_dec;
    logic              cnt_done, tx_pop, rx_push;
    logic [7:0]        tx_head, rx_head;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]     tx_count, rx_count;
    logic              wr, data_wr, ctrl_wr, data_rd, clr_ovf, flush;
    logic [2:0]        ie_val;
    logic [31:0]       rd_val;

    assign wr      = bus.en & bus.we;
    assign data_wr = wr && (bus.addr == MMSPI_DATA);
    assign ctrl_wr = wr && (bus.addr == MMSPI_CTRL);
    assign data_rd = bus.en && !bus.we && (bus.addr == MMSPI_DATA);
    assign clr_ovf = ctrl_wr & bus.wd[CTRL_CLR_OVF];
    assign flush   = ctrl_wr & bus.wd[CTRL_FLUSH];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk(clk), .rst(rst), .push(data_wr), .pop(tx_pop), .flush(flush),
        .din(bus.wd[7:0]), .dout(tx_head), .full(tx_full), .empty(tx_empty),
        .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk(clk), .rst(rst), .push(rx_push), .pop(data_rd), .flush(flush),
        .din(rx_sh), .dout(rx_head), .full(rx_full), .empty(rx_empty),
        .count(rx_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= div_sanitize(8'(SCK_WIDTH_CLKS));
            enable  <= 1'b1;
            ss_sel  <= '0;
            tx_ovf  <= 1'b0;
            rx_ovf  <= 1'b0;
        end else begin
            if (wr && (bus.addr == MMSPI_DIV)) div_reg <= div_sanitize(bus.wd[7:0]);
            if (ctrl_wr) begin
                ss_sel <= bus.wd[2:0];
                enable <= bus.wd[CTRL_ENABLE];
            end
            // A full FIFO only drops the incoming byte when nothing leaves it that cycle.
            if (clr_ovf) begin
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end else begin
                if (data_wr && tx_full && !tx_pop) tx_ovf <= 1'b1;
                if (rx_push && rx_full && !data_rd) rx_ovf <= 1'b1;
            end
        end
    end

`ifdef MEM_MAP_SPI_IRQ_EN
    logic [2:0] ie;
    logic       irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ie    <= '0;
            irq_q <= 1'b0;
        end else begin
            if (wr && (bus.addr == MMSPI_IE)) ie <= bus.wd[2:0];
            irq_q <= ((rx_count != '0) & ie[0]) | (tx_empty & ie[1]) |
                     ((rx_ovf | tx_ovf) & ie[2]);
        end
    end

    assign ie_val = ie;
    assign irq    = irq_q;
`else
    assign ie_val = '0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (bus.addr)
            MMSPI_DATA:   rd_val[7:0] = rx_empty ? 8'h00 : rx_head;
            MMSPI_STATUS: begin
                rd_val[STAT_TX_FULL]  = tx_full;
                rd_val[STAT_TX_EMPTY] = tx_empty;
                rd_val[STAT_RX_FULL]  = rx_full;
                rd_val[STAT_RX_EMPTY] = rx_empty;
                rd_val[STAT_BUSY]     = (state_q != S_IDLE);
                rd_val[STAT_RX_OVF]   = rx_ovf;
                rd_val[STAT_TX_OVF]   = tx_ovf;
                rd_val[15:8]          = 8'(tx_count);
                rd_val[23:16]         = 8'(rx_count);
            end
            MMSPI_CTRL: begin
                rd_val[2:0]         = ss_sel;
                rd_val[CTRL_ENABLE] = enable;
            end
            MMSPI_DIV:    rd_val[7:0] = div_reg;
            MMSPI_IE:     rd_val[2:0] = ie_val;
            default:      rd_val = '0;
        endcase
    end
    assign bus.rd = rd_val;

    // Selects beyond NUM_SS leave every line deasserted.
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (ss_sel == 3'(i)) ss_dec[i] = 1'b0;
        end
    end

    assign cnt_done = (cnt_q == div_q - 8'd1);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        case (state_q)
            S_IDLE:  if (enable && !tx_empty) state_d = S_LOAD;
            S_LOAD: begin
                tx_pop  = 1'b1;
                state_d = S_SHIFT;
            end
            S_SHIFT: if (cnt_done && half_q == 4'd15) state_d = S_DONE;
            S_DONE: begin
                if (cnt_done) begin
                    rx_push = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Even half-periods end with the SCK rise (sample), odd ones with the fall (advance mosi).
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= 8'd1;
            cnt_q  <= '0;
            half_q <= '0;
            tx_sh  <= '0;
            rx_sh  <= '0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
            ss_q   <= '1;
        end else begin
            case (state_q)
                S_LOAD: begin
                    tx_sh  <= tx_head;
                    div_q  <= div_reg;
                    cnt_q  <= '0;
                    half_q <= '0;
                    sck_q  <= 1'b0;
                    mosi_q <= tx_head[7];
                    ss_q   <= ss_dec;
                end
                S_SHIFT: begin
                    if (cnt_done) begin
                        cnt_q  <= '0;
                        half_q <= half_q + 4'd1;
                        if (!half_q[0]) begin
                            sck_q <= 1'b1;
                            rx_sh <= {rx_sh[6:0], miso};
                        end else begin
                            sck_q  <= 1'b0;
                            tx_sh  <= {tx_sh[6:0], 1'b0};
                            mosi_q <= tx_sh[6];
                            if (half_q == 4'd15) ss_q <= '1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE:  cnt_q <= cnt_done ? 8'd0 : cnt_q + 8'd1;
                default: ;
            endcase
        end
    end

    assign sck  = sck_q;
    assign mosi = mosi_q;
    assign ss   = ss_q;

endmodule
